neuron_mac_sequencer: RTL and testbench
=======================================

Name: neuron_mac_sequencer

Overview:
- Controller that sequences the fixed-point neuron ALU (coefficient-select register, fixed-point multiplier and adder) to compute one neuron output.
- Computes result = sum over k of (x_k · Coeff_k) + Offset, for k = 0..NumInputs-1.
- Accepts input samples on a valid/ready stream and drives the ALU's select, load and enable strobes.
- Owns the accumulator register fed back to the ALU, and reports the result with a one-cycle done pulse plus a sticky error flag.

Parameters:
- Width, 4, total fixed-point word width; must match the ALU instance.
- Precision, 1, fractional bits; sets the constant ONE = 1 << Precision (1.0). Constraint: Precision <= Width-2.
- NumInputs, 20, number of weighted terms per neuron, range 1..20.
- Magnitud, 2, integer bits; passed through for consistency only, no internal use.
- Signo, 1, sign bit count; passed through for consistency only, no internal use.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a neuron evaluation; sampled only in IDLE.
- in_valid  input  1  input sample valid.
- in_data  input  Width  signed input sample x_k.
- in_ready  output  1  sequencer accepts in_data this cycle.
- alu_sel_coeff  output  5  coefficient select; 0..19 select Coeff00..Coeff19, 20 selects Offset.
- alu_load_coeff  output  1  load strobe for the ALU coefficient register.
- alu_en_mul  output  1  multiplier enable.
- alu_en_sum  output  1  adder enable.
- alu_in_dato  output  Width  signed multiplier operand.
- alu_acumulador  output  Width  signed accumulator value fed to the ALU adder.
- alu_out_dato  input  Width  signed ALU sum result.
- alu_error  input  1  ALU overflow/saturation error.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  Width  signed neuron output; held until the next accepted start.
- error  output  1  sticky OR of alu_error over all MAC cycles of the current run.

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - state=IDLE; idx=0; acc=0; sample_reg=0.
  - result=0, error=0, done=0, in_ready=0.
  - All ALU strobes=0, alu_sel_coeff=0, alu_in_dato=0.
  - No partial result is ever reported.
- State machine (one state per cycle unless stalled):
  - IDLE: on start=1: acc<=0, idx<=0, error<=0, go to LOAD.
  - LOAD: alu_sel_coeff=idx, alu_load_coeff=1; go to FETCH.
  - FETCH: in_ready=1. If in_valid=1: sample_reg<=in_data, go to MAC. Otherwise stay; strobes stay 0 and the coefficient is not reloaded.
  - MAC:
    - alu_en_mul=alu_en_sum=1, alu_in_dato=sample_reg.
    - acc<=alu_out_dato; error<=error|alu_error.
    - If idx==NumInputs-1: go to LOAD_OFF. Else idx<=idx+1, go to LOAD.
  - LOAD_OFF: alu_sel_coeff=20, alu_load_coeff=1; go to MAC_OFF.
  - MAC_OFF:
    - alu_en_mul=alu_en_sum=1, alu_in_dato=ONE.
    - acc<=alu_out_dato; error<=error|alu_error.
    - Go to DONE.
  - DONE: done=1 for exactly one cycle; result<=acc in the same edge as entering DONE; go to IDLE.
- Output rules:
  - alu_acumulador=acc at all times.
  - alu_sel_coeff holds its last value outside the LOAD states.
  - alu_in_dato=0 outside the MAC states.
  - Strobes are decoded from registered state only; there is no combinational path from in_valid to any ALU strobe.
- Latency: with in_valid held high, done is asserted 3·NumInputs+3 cycles after the cycle in which start is sampled. Each FETCH stall cycle adds 1.
- start while busy=1 is ignored; it is not queued.
- in_ready is high only in FETCH. At most one sample is accepted per term, and exactly NumInputs samples are consumed per run.
- Arithmetic: no width growth in the sequencer. Saturation/overflow handling belongs to the ALU; the sequencer only records alu_error.
- error stays valid alongside result until the next accepted start clears it.

Test Plan:
- NumInputs=2, Coeff00=1.0 (4'b0010), Coeff01=0.5 (4'b0001), Offset=0.5; inputs 1.0, 1.0; in_valid constantly high; start pulsed -> done at cycle 9 after start, result=2.0 (4'b0100), error=0, in_ready high exactly 2 cycles.
- Same setup with in_valid low for 5 cycles during the first FETCH -> done at cycle 14, same result. alu_load_coeff pulses exactly 3 times (sel 0, 1, 20).
- ALU model forces alu_error=1 during the first MAC only -> error=1 at done and held after; next run with no error clears it to 0.
- start re-asserted every cycle during a run -> only one done pulse per run; the second run begins only after the sequencer returns to IDLE.
- reset asserted during MAC of term 1 -> busy, in_ready, strobes, result and acc go to 0 immediately; a subsequent start yields a correct full result.
- NumInputs=20 with all coefficients 0.5 and all inputs 0.5, Offset=0 -> alu_sel_coeff sequence 0..19 then 20, done at cycle 63, result equal to the ALU reference model.

Source files
------------

// File: rtl/neuron_mac_sequencer.sv
// Sequencer for the fixed-point neuron ALU: loads Coeff_k, consumes one stream sample x_k,
// accumulates x_k*Coeff_k for every term, then adds Offset and reports the result.
module neuron_mac_sequencer #(
    parameter int Width     = 4,
    parameter int Precision = 1,
    parameter int NumInputs = 20,
    parameter int Magnitud  = 2,
    parameter int Signo     = 1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [Width-1:0] in_data,
    output logic                    in_ready,
    output logic [4:0]              alu_sel_coeff,
    output logic                    alu_load_coeff,
    output logic                    alu_en_mul,
    output logic                    alu_en_sum,
    output logic signed [Width-1:0] alu_in_dato,
    output logic signed [Width-1:0] alu_acumulador,
    input  logic signed [Width-1:0] alu_out_dato,
    input  logic                    alu_error,
    output logic                    busy,
    output logic                    done,
    output logic signed [Width-1:0] result,
    output logic                    error,
    output logic [2:0]              dbg_state
);

    localparam logic [Width-1:0] ONE        = Width'(1 << Precision);
    localparam logic [4:0]       LAST_IDX   = 5'(NumInputs - 1);
    localparam logic [4:0]       OFFSET_SEL = 5'd20;

    if (Precision > Width - 2) begin : g_bad_precision
        $error("neuron_mac_sequencer: Precision must be <= Width-2");
    end
    if (Signo + Magnitud + Precision != Width) begin : g_bad_format
        $error("neuron_mac_sequencer: Signo+Magnitud+Precision must equal Width");
    end
    if (NumInputs < 1 || NumInputs > 20) begin : g_bad_inputs
        $error("neuron_mac_sequencer: NumInputs must be in 1..20");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        FETCH    = 3'd2,
        MAC      = 3'd3,
        LOAD_OFF = 3'd4,
        MAC_OFF  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                  state;
    logic [4:0]              idx;
    logic signed [Width-1:0] acc;

    assign alu_acumulador = acc;
    assign dbg_state      = state;

    // Input stream: a sample transfers on a rising edge where in_ready && in_valid.
    // in_ready is high only in FETCH and does not depend on in_valid.
    // All outputs are registered: each transition sets the outputs of the state it enters.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            acc            <= '0;
            result         <= '0;
            error          <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            in_ready       <= 1'b0;
            alu_sel_coeff  <= '0;
            alu_load_coeff <= 1'b0;
            alu_en_mul     <= 1'b0;
            alu_en_sum     <= 1'b0;
            alu_in_dato    <= '0;
        end else begin
            done           <= 1'b0;
            in_ready       <= 1'b0;
            alu_load_coeff <= 1'b0;
            alu_en_mul     <= 1'b0;
            alu_en_sum     <= 1'b0;
            alu_in_dato    <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc            <= '0;
                        idx            <= '0;
                        error          <= 1'b0;
                        busy           <= 1'b1;
                        alu_sel_coeff  <= '0;
                        alu_load_coeff <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    in_ready <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (in_valid) begin
                        // alu_in_dato doubles as the sample register for the MAC cycle.
                        alu_in_dato <= in_data;
                        alu_en_mul  <= 1'b1;
                        alu_en_sum  <= 1'b1;
                        state       <= MAC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MAC: begin
                    acc            <= alu_out_dato;
                    error          <= error | alu_error;
                    alu_load_coeff <= 1'b1;
                    if (idx == LAST_IDX) begin
                        alu_sel_coeff <= OFFSET_SEL;
                        state         <= LOAD_OFF;
                    end else begin
                        idx           <= idx + 5'd1;
                        alu_sel_coeff <= idx + 5'd1;
                        state         <= LOAD;
                    end
                end
                LOAD_OFF: begin
                    alu_in_dato <= ONE;
                    alu_en_mul  <= 1'b1;
                    alu_en_sum  <= 1'b1;
                    state       <= MAC_OFF;
                end
                MAC_OFF: begin
                    // The offset sum is the final value, so result captures it on the same edge as acc.
                    acc    <= alu_out_dato;
                    result <= alu_out_dato;
                    error  <= error | alu_error;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: a 2-term and a 20-term instance, each driving a small
// fixed-point ALU model, checked against a term-by-term arithmetic reference of the neuron.
module tb_neuron_mac_sequencer;

    localparam int W    = 4;
    localparam int P    = 1;
    localparam int ONE  = 1 << P;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start    [2];
    logic         in_valid [2];
    logic [W-1:0] in_data  [2];
    logic         in_ready [2];
    logic [4:0]   sel      [2];
    logic         load     [2];
    logic         en_mul   [2];
    logic         en_sum   [2];
    logic [W-1:0] in_dato  [2];
    logic [W-1:0] acum     [2];
    logic [W-1:0] out_dato [2];
    logic         err_in   [2];
    logic         busy     [2];
    logic         done     [2];
    logic [W-1:0] result   [2];
    logic         error    [2];
    logic [2:0]   dbg      [2];

    neuron_mac_sequencer #(.Width(W), .Precision(P), .NumInputs(2), .Magnitud(2), .Signo(1)) u_n2 (
        .CLK(clk), .reset(rst), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .alu_sel_coeff(sel[0]), .alu_load_coeff(load[0]),
        .alu_en_mul(en_mul[0]), .alu_en_sum(en_sum[0]), .alu_in_dato(in_dato[0]),
        .alu_acumulador(acum[0]), .alu_out_dato(out_dato[0]), .alu_error(err_in[0]),
        .busy(busy[0]), .done(done[0]), .result(result[0]), .error(error[0]), .dbg_state(dbg[0])
    );

    neuron_mac_sequencer #(.Width(W), .Precision(P), .NumInputs(20), .Magnitud(2), .Signo(1)) u_n20 (
        .CLK(clk), .reset(rst), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .alu_sel_coeff(sel[1]), .alu_load_coeff(load[1]),
        .alu_en_mul(en_mul[1]), .alu_en_sum(en_sum[1]), .alu_in_dato(in_dato[1]),
        .alu_acumulador(acum[1]), .alu_out_dato(out_dato[1]), .alu_error(err_in[1]),
        .busy(busy[1]), .done(done[1]), .result(result[1]), .error(error[1]), .dbg_state(dbg[1])
    );

    // ---------------- ALU environment ----------------
    int           coeff_tab [2][21];
    logic [W-1:0] coeff_reg [2];
    logic [W:0]   alu_res   [2];
    bit           inj_first [2];
    int           mac_cnt   [2];
    int           done_cnt  [2];
    int           load_n    [2];
    int           load_log  [2][24];

    function automatic logic [W:0] alu_fn(input logic signed [W-1:0] a, input logic signed [W-1:0] x,
                                          input logic signed [W-1:0] c);
        int s;
        s = int'(a) + ((int'(x) * int'(c)) >>> P);
        if (s > MAXV) return {1'b1, W'(MAXV)};
        if (s < MINV) return {1'b1, W'(MINV)};
        return {1'b0, W'(s)};
    endfunction

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            alu_res[u]  = alu_fn(acum[u], in_dato[u], coeff_reg[u]);
            out_dato[u] = alu_res[u][W-1:0];
            err_in[u]   = (alu_res[u][W] && en_sum[u]) || (inj_first[u] && en_mul[u] && mac_cnt[u] == 0);
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (load[u]) coeff_reg[u] <= W'(coeff_tab[u][sel[u]]);
            if (done[u]) done_cnt[u] <= done_cnt[u] + 1;
            if (start[u] && !busy[u]) begin
                mac_cnt[u] <= 0;
                load_n[u]  <= 0;
            end else begin
                if (en_mul[u]) mac_cnt[u] <= mac_cnt[u] + 1;
                if (load[u] && load_n[u] < 24) begin
                    load_log[u][load_n[u]] <= int'(sel[u]);
                    load_n[u]              <= load_n[u] + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int samp  [20];
    int stall [20];

    function automatic int floor_div(input int a, input int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    // Neuron value in LSB units: each term is floor(x*c / 1.0), running sum clamped to the
    // signed word range; any clamp (or an injected ALU fault) marks the run as erroneous.
    function automatic logic [W:0] ref_neuron(input int u, input int n, input bit inj);
        int acc;
        int term;
        bit e;
        acc = 0;
        e   = inj;
        for (int k = 0; k <= n; k++) begin
            term = (k < n) ? floor_div(samp[k] * coeff_tab[u][k], ONE) : coeff_tab[u][20];
            acc  = acc + term;
            if (acc > MAXV) begin acc = MAXV; e = 1'b1; end
            else if (acc < MINV) begin acc = MINV; e = 1'b1; end
        end
        return {e, W'(acc)};
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_run(input int u, input int n, input bit inj, input bit hold_start);
        int         edges, rdy, k, stall_left, total_stall, dc0;
        bit         seen;
        logic [W:0] mdl;
        logic [W-1:0] exp_r;
        mdl = ref_neuron(u, n, inj);
        exp_q.push_back(mdl[W-1:0]);
        total_stall = 0;
        for (int i = 0; i < n; i++) total_stall += stall[i];
        inj_first[u] = inj;
        edges = 0; rdy = 0; k = 0; seen = 1'b0;
        stall_left = stall[0];
        dc0 = done_cnt[u];
        @(negedge clk);
        start[u] = 1'b1;
        while (!seen && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done[u]) seen = 1'b1;
            start[u] = hold_start && !seen;
            if (in_ready[u]) begin
                rdy++;
                if (stall_left > 0) begin
                    in_valid[u] = 1'b0;
                    stall_left--;
                end else begin
                    in_valid[u] = 1'b1;
                    in_data[u]  = W'(samp[k < 20 ? k : 19]);
                    k++;
                    stall_left = (k < n) ? stall[k] : 0;
                end
            end else begin
                in_valid[u] = 1'($urandom_range(0, 1));
                in_data[u]  = W'($urandom_range(0, 15));
            end
        end
        exp_r = exp_q.pop_front();
        check("done_seen", 32'(seen), 32'd1);
        check("latency", edges, 3 * n + 3 + total_stall);
        check("result", 32'(result[u]), 32'(exp_r));
        check("error", 32'(error[u]), 32'(mdl[W]));
        check("accepted", k, n);
        check("ready_cycles", rdy, n + total_stall);
        check("load_count", load_n[u], n + 1);
        for (int i = 0; i < n && i < 24; i++) check("load_sel", load_log[u][i], i);
        check("load_sel_off", load_log[u][n], 20);
        start[u] = 1'b0;
        in_valid[u] = 1'b0;
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt[u] - dc0, 1);
        check("idle_after", 32'(busy[u]), 32'd0);
        check("result_held", 32'(result[u]), 32'(exp_r));
        check("error_held", 32'(error[u]), 32'(mdl[W]));
        inj_first[u] = 1'b0;
    endtask

    task automatic plan_setup2();
        coeff_tab[0][0]  = 2;
        coeff_tab[0][1]  = 1;
        coeff_tab[0][20] = 1;
        samp[0] = 2; samp[1] = 2;
        stall[0] = 0; stall[1] = 0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = '0;
            inj_first[u] = 1'b0; done_cnt[u] = 0; mac_cnt[u] = 0; load_n[u] = 0;
            coeff_reg[u] = '0;
            for (int i = 0; i < 21; i++) coeff_tab[u][i] = 0;
        end
        for (int i = 0; i < 20; i++) begin samp[i] = 0; stall[i] = 0; end

        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_result", 32'(result[u]), 32'd0);
            check("rst_busy", 32'(busy[u]), 32'd0);
            check("rst_ready", 32'(in_ready[u]), 32'd0);
            check("rst_acc", 32'(acum[u]), 32'd0);
            check("rst_sel", 32'(sel[u]), 32'd0);
            check("rst_done", 32'(done[u]), 32'd0);
            check("rst_error", 32'(error[u]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed: 1.0*1.0 + 1.0*0.5 + 0.5 = 2.0
        plan_setup2();
        do_run(0, 2, 1'b0, 1'b0);
        check("plan_result_2p0", 32'(result[0]), 32'd4);
        stall[0] = 5;
        do_run(0, 2, 1'b0, 1'b0);
        stall[0] = 0;
        do_run(0, 2, 1'b1, 1'b0);
        check("inj_error_set", 32'(error[0]), 32'd1);
        do_run(0, 2, 1'b0, 1'b0);
        check("inj_error_clear", 32'(error[0]), 32'd0);
        do_run(0, 2, 1'b0, 1'b1);

        // Reset in the MAC cycle of term 1.
        @(negedge clk);
        start[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 4'd2;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            start[0] = 1'b0;
        end
        check("pre_rst_mul", 32'(en_mul[0]), 32'd1);
        check("pre_rst_sel", 32'(sel[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_ready", 32'(in_ready[0]), 32'd0);
        check("mid_rst_mul", 32'(en_mul[0]), 32'd0);
        check("mid_rst_sum", 32'(en_sum[0]), 32'd0);
        check("mid_rst_dato", 32'(in_dato[0]), 32'd0);
        check("mid_rst_acc", 32'(acum[0]), 32'd0);
        check("mid_rst_result", 32'(result[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid[0] = 1'b0;
        @(negedge clk);
        check("post_rst_done", done_cnt[0] - done_cnt[0], 0);
        plan_setup2();
        do_run(0, 2, 1'b0, 1'b0);
        check("post_rst_result", 32'(result[0]), 32'd4);

        // 20 terms of 0.5*0.5 with zero offset.
        for (int i = 0; i < 20; i++) begin coeff_tab[1][i] = 1; samp[i] = 1; stall[i] = 0; end
        coeff_tab[1][20] = 0;
        do_run(1, 20, 1'b0, 1'b0);

        // Randomized runs on both instances.
        for (int r = 0; r < 12; r++) begin
            int u;
            int n;
            u = r % 2;
            n = (u == 0) ? 2 : 20;
            for (int i = 0; i < n; i++) begin
                coeff_tab[u][i] = int'($urandom_range(0, 15)) - 8;
                samp[i]         = int'($urandom_range(0, 15)) - 8;
                stall[i]        = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            coeff_tab[u][20] = int'($urandom_range(0, 7)) - 4;
            do_run(u, n, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
